// File: rtl/fft_io_pkg.sv
// rtl/fft_io_pkg.sv - shared types and constants for the FFT frame I/O scheduler
package fft_io_pkg;

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    READY   = 2'd1,
    COMPUTE = 2'd2
  } state_t;

  localparam logic [1:0] OUT_EN_RE = 2'd1;
  localparam logic [1:0] OUT_EN_IM = 2'd2;

  localparam int ERR_UNDERRUN = 0;
  localparam int ERR_RES_OVF  = 1;
  localparam int ERR_SEQ      = 2;

endpackage

// File: rtl/fft_io_sched_if.sv
// rtl/fft_io_sched_if.sv - sample source, core I/O and result signals of fft_io_sched
interface fft_io_sched_if #(
  parameter int IN_W  = 23,
  parameter int OUT_W = 32
);
  logic [IN_W-1:0]  src_data;
  logic             src_valid;
  logic             src_ready;
  logic [IN_W-1:0]  proc_io_in;
  logic             proc_req_in;
  logic [OUT_W-1:0] proc_io_out;
  logic [1:0]       proc_out_en;
  logic             proc_itr;
  logic [OUT_W-1:0] res_re;
  logic [OUT_W-1:0] res_im;
  logic             res_valid;
  logic             res_ready;
  logic [15:0]      frame_cnt;
  logic [2:0]       err_flags;

  modport slave (
    input  src_data, src_valid, proc_req_in, proc_io_out, proc_out_en, res_ready,
    output src_ready, proc_io_in, proc_itr, res_re, res_im, res_valid, frame_cnt, err_flags
  );

  modport master (
    output src_data, src_valid, proc_req_in, proc_io_out, proc_out_en, res_ready,
    input  src_ready, proc_io_in, proc_itr, res_re, res_im, res_valid, frame_cnt, err_flags
  );
endinterface

// File: rtl/fft_frame_buf.sv
// rtl/fft_frame_buf.sv - NPTS x IN_W frame register file, synchronous write, asynchronous read
module fft_frame_buf #(
  parameter int IN_W   = 23,
  parameter int NPTS   = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [IN_W-1:0]   i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [IN_W-1:0]   o_rdata
);
  logic [IN_W-1:0] r_mem [NPTS];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/fft_io_sched.sv
// rtl/fft_io_sched.sv - frame buffer, core input serving and result pairing for proc_fft
module fft_io_sched
  import fft_io_pkg::*;
#(
  parameter int IN_W   = 23,
  parameter int OUT_W  = 32,
  parameter int NPTS   = 16,
  parameter int ADDR_W = 4
) (
  input logic          clk,
  input logic          rst,
  fft_io_sched_if.slave bus
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NPTS - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W-1:0] r_pair_cnt;
  logic              r_src_ready;
  logic              r_itr;
  logic              r_re_pend;
  logic [OUT_W-1:0]  r_re_hold;
  logic [OUT_W-1:0]  r_res_re;
  logic [OUT_W-1:0]  r_res_im;
  logic              r_res_valid;
  logic [15:0]       r_frame_cnt;
  logic [2:0]        r_err;

  logic              w_wr_en;
  logic              w_rd_en;
  logic              w_re_in;
  logic              w_im_in;
  logic              w_pair;
  logic              w_res_busy;
  logic [IN_W-1:0]   w_rd_data;

  assign w_wr_en    = r_src_ready && bus.src_valid && (r_state == FILL);
  assign w_rd_en    = bus.proc_req_in && (r_state == READY);
  assign w_re_in    = (bus.proc_out_en == OUT_EN_RE);
  assign w_im_in    = (bus.proc_out_en == OUT_EN_IM);
  assign w_pair     = w_im_in && r_re_pend;
  assign w_res_busy = r_res_valid && !bus.res_ready;

  fft_frame_buf #(
    .IN_W  (IN_W),
    .NPTS  (NPTS),
    .ADDR_W(ADDR_W)
  ) u_buf (
    .clk    (clk),
    .i_we   (w_wr_en),
    .i_waddr(r_wr_ptr),
    .i_wdata(bus.src_data),
    .i_raddr(r_rd_ptr),
    .o_rdata(w_rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= FILL;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_pair_cnt  <= '0;
      r_src_ready <= 1'b0;
      r_itr       <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_itr <= 1'b0;
      case (r_state)
        FILL: begin
          r_src_ready <= 1'b1;
          if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            if (r_wr_ptr == LAST) begin
              r_state     <= READY;
              r_itr       <= 1'b1;
              r_src_ready <= 1'b0;
            end
          end
        end
        READY: begin
          r_src_ready <= 1'b0;
          if (w_rd_en) begin
            // Pointer wraps to zero on the last read, leaving it cleared for COMPUTE.
            r_rd_ptr <= r_rd_ptr + 1'b1;
            if (r_rd_ptr == LAST) r_state <= COMPUTE;
          end
        end
        COMPUTE: begin
          r_src_ready <= 1'b0;
          if (w_pair) begin
            r_pair_cnt <= r_pair_cnt + 1'b1;
            if (r_pair_cnt == LAST) begin
              r_frame_cnt <= r_frame_cnt + 1'b1;
              r_wr_ptr    <= '0;
              r_state     <= FILL;
              r_src_ready <= 1'b1;
            end
          end
        end
        default: begin
          r_state     <= FILL;
          r_src_ready <= 1'b0;
        end
      endcase
    end
  end

  // Pairing of real/imag core outputs and the single-entry result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_re_pend   <= 1'b0;
      r_re_hold   <= '0;
      r_res_re    <= '0;
      r_res_im    <= '0;
      r_res_valid <= 1'b0;
      r_err       <= '0;
    end else begin
      if (bus.proc_req_in && (r_state != READY)) r_err[ERR_UNDERRUN] <= 1'b1;

      if (w_re_in) begin
        r_re_hold <= bus.proc_io_out;
        r_re_pend <= 1'b1;
        if (r_re_pend) r_err[ERR_SEQ] <= 1'b1;
      end else if (w_im_in) begin
        r_re_pend <= 1'b0;
        if (!r_re_pend || (r_state != COMPUTE)) r_err[ERR_SEQ] <= 1'b1;
      end

      if (w_pair) begin
        if (w_res_busy) begin
          r_err[ERR_RES_OVF] <= 1'b1;
        end else begin
          r_res_re    <= r_re_hold;
          r_res_im    <= bus.proc_io_out;
          r_res_valid <= 1'b1;
        end
      end else if (r_res_valid && bus.res_ready) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign bus.src_ready  = r_src_ready;
  assign bus.proc_io_in = w_rd_en ? w_rd_data : '0;
  assign bus.proc_itr   = r_itr;
  assign bus.res_re     = r_res_re;
  assign bus.res_im     = r_res_im;
  assign bus.res_valid  = r_res_valid;
  assign bus.frame_cnt  = r_frame_cnt;
  assign bus.err_flags  = r_err;
endmodule

// File: tb/tb_fft_io_sched.sv
// tb/tb_fft_io_sched.sv - directed table-driven bench for fft_io_sched
module tb_fft_io_sched;
  localparam int IN_W  = 23;
  localparam int OUT_W = 32;
  localparam int NPTS  = 16;

  typedef struct {
    logic [IN_W-1:0]  samp;
    logic [OUT_W-1:0] re;
    logic [OUT_W-1:0] im;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t tbl [NPTS];

  fft_io_sched_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  fft_io_sched #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .NPTS  (NPTS),
    .ADDR_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.src_valid   = 1'b0;
    bus.proc_req_in = 1'b0;
    bus.proc_out_en = 2'd0;
    bus.res_ready   = 1'b0;
    rst = 1'b1;
    tick();
    chk("rst_src_ready", bus.src_ready, 0);
    chk("rst_itr", bus.proc_itr, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_re", bus.res_re, 0);
    chk("rst_res_im", bus.res_im, 0);
    chk("rst_frame_cnt", bus.frame_cnt, 0);
    chk("rst_err", bus.err_flags, 0);
    chk("rst_io_in", bus.proc_io_in, 0);
    rst = 1'b0;
  endtask

  // Feeds tbl[start .. start+n-1]; proc_itr must rise only after the frame's last sample.
  task automatic feed(input int start, input int n, input bit completes);
    int  k = 0;
    int  guard = 0;
    logic hs;
    while (k < n && guard < 100) begin
      bus.src_data  = tbl[start + k].samp;
      bus.src_valid = 1'b1;
      @(negedge clk);
      hs = bus.src_ready;
      tick();
      if (hs) begin
        k++;
        chk("feed_itr", bus.proc_itr, (completes && k == n) ? 1 : 0);
      end
      guard++;
    end
    bus.src_valid = 1'b0;
    if (guard >= 100) chk("feed_timeout", k, n);
    if (completes) begin
      chk("ready_drop", bus.src_ready, 0);
      tick();
      chk("itr_one_cycle", bus.proc_itr, 0);
    end
  endtask

  task automatic read_frame();
    for (int k = 0; k < NPTS; k++) begin
      bus.proc_req_in = 1'b1;
      #1;
      chk("rd_data", bus.proc_io_in, tbl[k].samp);
      tick();
      bus.proc_req_in = 1'b0;
      #1;
      chk("rd_gap", bus.proc_io_in, 0);
      tick();
    end
  endtask

  task automatic send_pair(input int k, input logic rdy_re, input logic rdy_im);
    bus.proc_out_en = 2'd1;
    bus.proc_io_out = tbl[k].re;
    bus.res_ready   = rdy_re;
    tick();
    bus.proc_out_en = 2'd2;
    bus.proc_io_out = tbl[k].im;
    bus.res_ready   = rdy_im;
    tick();
    bus.proc_out_en = 2'd0;
    bus.proc_io_out = '0;
  endtask

  initial begin
    bus.src_data    = '0;
    bus.src_valid   = 1'b0;
    bus.proc_req_in = 1'b0;
    bus.proc_io_out = '0;
    bus.proc_out_en = 2'd0;
    bus.res_ready   = 1'b0;
    for (int k = 0; k < NPTS; k++) begin
      tbl[k].samp = IN_W'(k + 1);
      tbl[k].re   = OUT_W'(100 + k);
      tbl[k].im   = OUT_W'(-5 - k);
    end
    tick();
    do_reset();

    // Frame 1: fill, read with gaps, 16 pairs with downstream always ready.
    feed(0, NPTS, 1'b1);
    chk("f1_frame_cnt", bus.frame_cnt, 0);
    read_frame();
    chk("f1_ready_in_compute", bus.src_ready, 0);
    for (int k = 0; k < NPTS; k++) begin
      send_pair(k, 1'b1, 1'b1);
      chk("f1_res_valid", bus.res_valid, 1);
      chk("f1_res_re", bus.res_re, tbl[k].re);
      chk("f1_res_im", bus.res_im, tbl[k].im);
    end
    chk("f1_frame_cnt_done", bus.frame_cnt, 1);
    chk("f1_src_ready", bus.src_ready, 1);
    chk("f1_err", bus.err_flags, 0);

    // Frame 2 with signed samples; underrun and orphan imag while filling.
    do_reset();
    tbl[0].samp = 23'h400000;
    for (int k = 1; k < NPTS; k++) tbl[k].samp = IN_W'(-1000 * k - 1);
    feed(0, 3, 1'b0);
    bus.proc_req_in = 1'b1;
    bus.proc_out_en = 2'd2;
    bus.proc_io_out = 32'h12345678;
    #1;
    chk("fill_req_io_in", bus.proc_io_in, 0);
    tick();
    bus.proc_req_in = 1'b0;
    bus.proc_out_en = 2'd0;
    chk("fill_err_101", bus.err_flags, 3'b101);
    chk("fill_no_res", bus.res_valid, 0);
    feed(3, NPTS - 3, 1'b1);
    read_frame();

    // Result overflow: second pair while first is unacknowledged.
    send_pair(0, 1'b0, 1'b0);
    chk("ovf_first_valid", bus.res_valid, 1);
    chk("ovf_first_re", bus.res_re, tbl[0].re);
    send_pair(1, 1'b0, 1'b0);
    chk("ovf_err1", bus.err_flags[1], 1);
    chk("ovf_hold_re", bus.res_re, tbl[0].re);
    chk("ovf_hold_im", bus.res_im, tbl[0].im);
    bus.res_ready = 1'b1;
    tick();
    chk("ovf_handshake", bus.res_valid, 0);
    for (int k = 2; k < NPTS; k++) begin
      send_pair(k, 1'b0, 1'b1);
      chk("f2_res_valid", bus.res_valid, 1);
      chk("f2_res_re", bus.res_re, tbl[k].re);
      chk("f2_res_im", bus.res_im, tbl[k].im);
    end
    chk("f2_frame_cnt", bus.frame_cnt, 1);
    chk("f2_src_ready", bus.src_ready, 1);
    chk("f2_err", bus.err_flags, 3'b111);
    bus.res_ready = 1'b0;

    // Reset mid-frame: seven samples lost, a full frame is needed again.
    feed(0, 7, 1'b0);
    do_reset();
    feed(0, NPTS - 1, 1'b0);
    feed(NPTS - 1, 1, 1'b1);
    chk("post_rst_frame_cnt", bus.frame_cnt, 0);
    read_frame();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fft_io_sched.md
Name: fft_io_sched

Overview:
- Frame-level I/O scheduler between a sample stream and the proc_fft SAPHO core.
- Buffers one NPTS-sample input frame and pulses the processor interrupt when the frame is complete.
- Serves the frame on the core's input port, one sample per proc_req_in cycle.
- Pairs the core's two output channels (out_en 1 = real, 2 = imag) into result tuples with a valid/ready handshake, then rearms for the next frame.

Parameters:
- IN_W, 23, width of input samples and proc_io_in.
- OUT_W, 32, width of proc_io_out and of the result words.
- NPTS, 16, FFT points per frame; power of two, minimum 2.
- ADDR_W, 4, log2(NPTS); used for the buffer pointers.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- src_data  in  IN_W  signed input sample.
- src_valid  in  1  src_data valid.
- src_ready  out  1  block accepts a sample this cycle.
- proc_io_in  out  IN_W  sample presented to the core.
- proc_req_in  in  1  core reads the input port this cycle.
- proc_io_out  in  OUT_W  core output data.
- proc_out_en  in  2  core output address: 1 = real, 2 = imag, 0/3 = idle.
- proc_itr  out  1  one-cycle frame-ready interrupt to the core.
- res_re  out  OUT_W  real part of the result pair.
- res_im  out  OUT_W  imaginary part of the result pair.
- res_valid  out  1  result pair valid.
- res_ready  in  1  downstream accepts the pair.
- frame_cnt  out  16  completed frames; wraps at 65535 -> 0.
- err_flags  out  3  sticky flags: [0] underrun, [1] result overflow, [2] sequence error.

Behaviour:
- Reset: FSM to FILL; pointers, counters and flags cleared; all outputs 0.
- FSM FILL:
  - src_ready = 1.
  - Each src_valid & src_ready handshake writes buf[wr_ptr] and increments wr_ptr.
  - On the NPTS-th write: go to READY, pulse proc_itr high for exactly the next cycle.
- FSM READY:
  - src_ready = 0.
  - proc_io_in = buf[rd_ptr] when proc_req_in = 1, else 0. This is combinational; the core samples it in the same cycle.
  - rd_ptr increments on each proc_req_in = 1 cycle.
  - After the NPTS-th read: go to COMPUTE with rd_ptr = 0.
- FSM COMPUTE:
  - Collects NPTS result pairs.
  - On the NPTS-th delivered pair: frame_cnt += 1, wr_ptr = 0, go to FILL.
- proc_req_in while in FILL or COMPUTE: proc_io_in = 0, no pointer change, set err_flags[0].
- Output pairing (all states):
  - out_en = 1 latches proc_io_out into re_hold and sets re_pend.
  - out_en = 2 with re_pend set forms the pair {re_hold, proc_io_out} and clears re_pend.
  - out_en = 2 without re_pend: data dropped, set err_flags[2].
  - out_en = 1 while re_pend is already set: overwrite re_hold, set err_flags[2].
  - Pairs count toward completion only in COMPUTE. Outside COMPUTE a completed pair is still presented but sets err_flags[2].
- Result register:
  - A completed pair loads res_re/res_im and sets res_valid the next cycle.
  - res_valid holds until res_valid & res_ready.
  - New pair while res_valid & !res_ready: pair dropped, set err_flags[1]; it still counts toward NPTS.
  - Pair arriving in the same cycle as the handshake: accepted, res_valid stays 1.
- Latency:
  - src handshake -> proc_itr: 1 cycle after the last sample.
  - out_en = 2 -> res_valid: 1 cycle.
- Reset mid-frame: frame abandoned, no proc_itr, frame_cnt and err_flags cleared.
- Sign: samples stored and passed unmodified; no width conversion.

Decomposition:
- Package fft_io_pkg holds:
  - state enum {FILL, READY, COMPUTE};
  - constants OUT_EN_RE = 2'd1, OUT_EN_IM = 2'd2;
  - err_flags bit indices.
- Sub-module fft_frame_buf: NPTS x IN_W register file with synchronous write and asynchronous read, so proc_io_in stays combinational.
- FSM and pairing logic stay in the top module.

Test Plan:
- Reset, then feed samples 1..16 with src_valid held -> src_ready drops after the 16th; proc_itr high for 1 cycle; frame_cnt = 0.
- In READY, pulse proc_req_in 16 times with gaps -> proc_io_in = 1..16 in order, 0 between pulses; FSM enters COMPUTE.
- In COMPUTE, out_en = 1 with 100 then out_en = 2 with -5, res_ready = 1 -> next cycle res_re = 100, res_im = -5, res_valid = 1. After 16 such pairs: frame_cnt = 1, src_ready = 1.
- res_ready = 0, two pairs back-to-back -> first pair held, err_flags[1] = 1, res values unchanged until the handshake.
- proc_req_in during FILL; out_en = 2 with no prior real -> proc_io_in = 0, err_flags = 3'b101, wr_ptr unchanged.
- Assert rst after 7 samples -> all outputs 0, FSM in FILL; 16 new samples are then needed before proc_itr fires.
